// File: rtl/mini_alu_seq.sv
// ---------------------------------------------------------------------------
// mini_alu_seq
//
// Program sequencer for the mini ALU register file. A small instruction store
// of 8-bit {op,x,y,z} words is loaded over a write port while the sequencer is
// idle. A start pulse then issues the words in order to the ALU datapath over
// a valid/ready handshake, either free-running or one instruction per step
// pulse.
//
// Optional feature (macro MINI_ALU_SEQ_LOOP_EN):
//   defined     - after the last instruction is accepted, done pulses and the
//                 program restarts from pc 0 until abort.
//   not defined - after the last instruction is accepted, done pulses and the
//                 sequencer returns to IDLE.
//
// Parameters:
//   DEPTH        number of instruction words (power of 2, >= 2)
//   AW           address / pc width, derived from DEPTH
//
// Ports:
//   clk          system clock, all state on posedge
//   rst          asynchronous active-high reset
//   prog_we      instruction store write strobe (honoured only in IDLE)
//   prog_addr    instruction store write address
//   prog_data    instruction word to write
//   prog_len     instruction count, sampled on an accepted start
//   start        begin execution at pc 0 (pulse, honoured only in IDLE)
//   step_mode    1 = single-step, sampled on an accepted start
//   step         advance one instruction while waiting in step mode
//   abort        stop execution and return to IDLE
//   instr_out    instruction presented to the datapath
//   instr_valid  instr_out valid, held until instr_ready
//   instr_ready  datapath accepts instr_out this cycle
//   pc           index of the instruction being fetched / issued
//   busy         high in any state other than IDLE
//   done         one-cycle pulse after the last instruction is accepted
// ---------------------------------------------------------------------------
module mini_alu_seq #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    input  logic          abort,
    output logic [7:0]    instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_STEP, ISSUE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [AW:0]   len, len_nxt;
    logic          smode, smode_nxt;
    logic [AW-1:0] pc_nxt;
    logic [7:0]    out_nxt;
    logic          valid_nxt;
    logic          done_nxt;
    logic          hs;
    logic          last;

    logic [7:0]    mem [DEPTH];

    // The store has no reset; it is only writable while idle so a running
    // program can never be modified underneath the sequencer.
    always_ff @(posedge clk) begin
        if (prog_we && state == IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign hs   = instr_valid & instr_ready;
    assign last = ({1'b0, pc} == (len - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len         <= '0;
            smode       <= 1'b0;
            pc          <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            smode       <= smode_nxt;
            pc          <= pc_nxt;
            instr_out   <= out_nxt;
            instr_valid <= valid_nxt;
            busy        <= (state_nxt != IDLE);
            done        <= done_nxt;
        end
    end

    // Every output is registered, so this block computes next values for all
    // of them. Abort outranks everything else, including a coincident
    // handshake: that instruction is simply treated as consumed.
    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        smode_nxt = smode;
        pc_nxt    = pc;
        out_nxt   = instr_out;
        valid_nxt = instr_valid;
        done_nxt  = 1'b0;

        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            pc_nxt    = '0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (prog_len == '0) begin
                            // Empty program completes immediately.
                            done_nxt = 1'b1;
                        end else begin
                            len_nxt   = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
                            smode_nxt = step_mode;
                            pc_nxt    = '0;
                            state_nxt = FETCH;
                        end
                    end
                end
                FETCH: begin
                    out_nxt = mem[pc];
                    if (smode) begin
                        state_nxt = WAIT_STEP;
                    end else begin
                        state_nxt = ISSUE;
                        valid_nxt = 1'b1;
                    end
                end
                WAIT_STEP: begin
                    if (step) begin
                        state_nxt = ISSUE;
                        valid_nxt = 1'b1;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        valid_nxt = 1'b0;
                        if (last) begin
                            done_nxt  = 1'b1;
                            pc_nxt    = '0;
`ifdef MINI_ALU_SEQ_LOOP_EN
                            state_nxt = FETCH;
`else
                            state_nxt = IDLE;
`endif
                        end else begin
                            pc_nxt    = pc + 1'b1;
                            state_nxt = FETCH;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mini_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_mini_alu_seq
//
// Self-checking bench for mini_alu_seq (DEPTH = 16). Inputs are driven and
// outputs are compared on the falling clock edge; the DUT acts on the rising
// edge. Table rows hold the expected outputs at a falling edge together with
// the inputs to drive for the following rising edge.
// ---------------------------------------------------------------------------
module tb_mini_alu_seq;

    logic       clk;
    logic       rst;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [4:0] prog_len;
    logic       start;
    logic       step_mode;
    logic       step;
    logic       abort;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] pc;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    typedef struct {
        logic       st;
        logic       we;
        logic       sp;
        logic       ab;
        logic       rd;
        logic       ev;
        logic [7:0] eo;
        logic       co;
        logic [3:0] ep;
        logic       cp;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t vecs[$];

    mini_alu_seq #(.DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .abort       (abort),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every accepted instruction so duplicate or missing issues show up.
    always @(posedge clk) begin
        if (!rst && instr_valid && instr_ready) hs_count++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [7:0] word_of(input int i);
        return 8'(i * 13 + 5);
    endfunction

    function automatic void add(input logic st, we, sp, ab, rd, ev,
                                input logic [7:0] eo, input logic co,
                                input logic [3:0] ep, input logic cp,
                                input logic eb, ed);
        vec_t v;
        v.st = st; v.we = we; v.sp = sp; v.ab = ab; v.rd = rd;
        v.ev = ev; v.eo = eo; v.co = co; v.ep = ep; v.cp = cp;
        v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start       = v.st;
        prog_we     = v.we;
        prog_addr   = 4'd2;
        prog_data   = 8'hFF;
        step        = v.sp;
        abort       = v.ab;
        instr_ready = v.rd;
    endtask

    task automatic drive_idle();
        start       = 1'b0;
        prog_we     = 1'b0;
        step        = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic load_basic();
        load_word(4'd0, 8'h05);
        load_word(4'd1, 8'h46);
        load_word(4'd2, 8'h8B);
    endtask

    task automatic run_table(input string tag, input int exp_hs);
        int base;
        base = hs_count;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s[%0d] valid", tag, i), {7'd0, instr_valid}, {7'd0, vecs[i].ev});
            if (vecs[i].co) checkOutput($sformatf("%s[%0d] instr_out", tag, i), instr_out, vecs[i].eo);
            if (vecs[i].cp) checkOutput($sformatf("%s[%0d] pc", tag, i), {4'd0, pc}, {4'd0, vecs[i].ep});
            checkOutput($sformatf("%s[%0d] busy", tag, i), {7'd0, busy}, {7'd0, vecs[i].eb});
            checkOutput($sformatf("%s[%0d] done", tag, i), {7'd0, done}, {7'd0, vecs[i].ed});
            applyStimulus(vecs[i]);
        end
        drive_idle();
        checkOutput($sformatf("%s handshakes", tag), 8'(hs_count - base), 8'(exp_hs));
        vecs.delete();
    endtask

    // Step mode, len 2: abort while waiting for the step of the second word.
    task automatic seq_abort();
        step_mode = 1'b1; prog_len = 5'd2;
        //   st we sp ab rd  ev eo    co ep cp eb ed
        add(1, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h05, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 1,  0, 8'h05, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h05, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h05, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1,  0, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0, 0);
        run_table("abort", 1);
    endtask

    task automatic seq_len0();
        step_mode = 1'b0; prog_len = 5'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("len0 done", {7'd0, done}, 8'd1);
        checkOutput("len0 busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        checkOutput("len0 done end", {7'd0, done}, 8'd0);
        checkOutput("len0 busy end", {7'd0, busy}, 8'd0);
    endtask

    task automatic seq_reset_mid();
        step_mode = 1'b0; prog_len = 5'd3; instr_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("rstmid valid before", {7'd0, instr_valid}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid instr_out", instr_out, 8'h00);
        checkOutput("rstmid valid", {7'd0, instr_valid}, 8'd0);
        checkOutput("rstmid pc", {4'd0, pc}, 8'd0);
        checkOutput("rstmid busy", {7'd0, busy}, 8'd0);
        checkOutput("rstmid done", {7'd0, done}, 8'd0);
        rst = 1'b0;
        instr_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        prog_addr = '0; prog_data = '0; prog_len = '0;
        step_mode = 1'b0; instr_ready = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset instr_out", instr_out, 8'h00);
        checkOutput("reset valid", {7'd0, instr_valid}, 8'd0);
        checkOutput("reset pc", {4'd0, pc}, 8'd0);
        checkOutput("reset busy", {7'd0, busy}, 8'd0);
        checkOutput("reset done", {7'd0, done}, 8'd0);

        load_basic();

`ifndef MINI_ALU_SEQ_LOOP_EN
        // Free run, ready high; start and a store write while busy are ignored.
        step_mode = 1'b0; prog_len = 5'd3;
        //   st we sp ab rd  ev eo    co ep cp eb ed
        add(1, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h05, 1, 0, 1, 1, 0);
        add(1, 1, 0, 0, 1,  0, 8'h05, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h46, 1, 2, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h8B, 1, 2, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h8B, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1,  0, 8'h8B, 1, 0, 0, 0, 0);
        run_table("free", 3);

        // Datapath stalls word 2 for five cycles.
        //   st we sp ab rd  ev eo    co ep cp eb ed
        add(1, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h05, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0,  0, 8'h05, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h46, 1, 2, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h8B, 1, 2, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h8B, 1, 0, 0, 0, 1);
        run_table("stall", 3);

        // Single step, len 2; a step pulse during FETCH is ignored.
        step_mode = 1'b1; prog_len = 5'd2;
        //   st we sp ab rd  ev eo    co ep cp eb ed
        add(1, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h05, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 1,  0, 8'h05, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h05, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 1,  0, 8'h05, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 1, 0, 1,  0, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h46, 1, 0, 0, 0, 1);
        run_table("step", 2);
`endif

        seq_abort();
        seq_len0();
        seq_reset_mid();

`ifndef MINI_ALU_SEQ_LOOP_EN
        // Write and start in the same idle cycle: the new word is issued.
        step_mode = 1'b0; prog_len = 5'd1; instr_ready = 1'b1;
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hC3; start = 1'b1;
        @(negedge clk);
        drive_idle();
        checkOutput("wrstart busy", {7'd0, busy}, 8'd1);
        @(negedge clk);
        checkOutput("wrstart valid", {7'd0, instr_valid}, 8'd1);
        checkOutput("wrstart instr_out", instr_out, 8'hC3);
        @(negedge clk);
        checkOutput("wrstart done", {7'd0, done}, 8'd1);

        // prog_len above DEPTH is clamped to 16 instructions.
        begin
            int base;
            int issued;
            logic got_done;
            for (int i = 0; i < 16; i++) load_word(4'(i), word_of(i));
            step_mode = 1'b0; prog_len = 5'd31; instr_ready = 1'b1;
            base = hs_count; issued = 0; got_done = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 80 && !got_done; c++) begin
                if (instr_valid) begin
                    checkOutput($sformatf("clamp instr %0d", issued), instr_out, word_of(issued));
                    checkOutput($sformatf("clamp pc %0d", issued), {4'd0, pc}, 8'(issued % 16));
                    issued++;
                end
                if (done) got_done = 1'b1;
                else @(negedge clk);
            end
            checkOutput("clamp done seen", {7'd0, got_done}, 8'd1);
            checkOutput("clamp handshakes", 8'(hs_count - base), 8'd16);
            checkOutput("clamp busy end", {7'd0, busy}, 8'd0);
        end
`else
        // Looping program of two words repeats until aborted.
        load_basic();
        step_mode = 1'b0; prog_len = 5'd2; instr_ready = 1'b1;
        //   st we sp ab rd  ev eo    co ep cp eb ed
        add(1, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h05, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h05, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h46, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 1,  1, 8'h05, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 8'h05, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1,  1, 8'h46, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1,  0, 8'h46, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 1,  0, 8'h46, 1, 0, 1, 0, 0);
        run_table("loop", 4);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
